rf_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the 4 x 8-bit, one-write/two-read register file. Each requester issues single-beat transactions through a valid/ready handshake. A transaction carries an optional write plus two read addresses. The block drives the register file ports, holds write data for the file's two-cycle commit, and routes each read result back to its requester. It sits between the control units and the register file and is the only agent that drives register file ports.

---
 rtl/rf_arbiter.sv | 139 +++++++++++++
 tb/tb_rf_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_arbiter.sv
// Round-robin arbiter and sequencer in front of the 4x8 1W/2R register file.
// It accepts single-beat transactions from two requesters and returns a response pulse per accepted transaction.
module rf_arbiter #(
  parameter int PRIO_INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic       a_we,
  input  logic [1:0] a_waddr,
  input  logic [7:0] a_wdata,
  input  logic [1:0] a_raddr0,
  input  logic [1:0] a_raddr1,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic       b_we,
  input  logic [1:0] b_waddr,
  input  logic [7:0] b_wdata,
  input  logic [1:0] b_raddr0,
  input  logic [1:0] b_raddr1,
  output logic       a_resp_valid,
  output logic       b_resp_valid,
  output logic [7:0] resp_data0,
  output logic [7:0] resp_data1,
  output logic       rf_wr_en,
  output logic [1:0] rf_wr_addr,
  output logic [7:0] rf_wr_data,
  output logic [1:0] rf_rda_addr,
  output logic [1:0] rf_rdb_addr,
  input  logic [7:0] rf_rd_data1,
  input  logic [7:0] rf_rd_data2
);

  localparam int NREQ   = 2;
  localparam int STAGES = 3;

  typedef struct packed {
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic [1:0] raddr0;
    logic [1:0] raddr1;
  } req_t;

  typedef enum logic {IDLE = 1'b0, WHOLD = 1'b1} state_t;

  state_t state, state_nxt;

  req_t [NREQ-1:0] req;
  req_t            cur;
  logic [NREQ-1:0] valid, gnt, ready, resp;
  logic            prio, sel, accept, idle;
  logic [STAGES:1] vld_pipe, id_pipe;

  assign req[0] = {a_we, a_waddr, a_wdata, a_raddr0, a_raddr1};
  assign req[1] = {b_we, b_waddr, b_wdata, b_raddr0, b_raddr1};
  assign valid  = {b_valid, a_valid};

  // Contention goes to the pointer; a lone requester always wins.
  always_comb begin
    gnt = '0;
    if (&valid) gnt[prio] = 1'b1;
    else        gnt = valid;
  end

  assign sel    = gnt[1];
  assign cur    = req[sel];
  assign ready  = gnt & {NREQ{idle & ~rst}};
  assign accept = |ready;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && cur.we) state_nxt = WHOLD;
      WHOLD:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    idle = (state == IDLE);
  end

  // Write data/address stay put through WHOLD so the file samples data on its second edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio        <= (PRIO_INIT != 0);
      rf_wr_en    <= 1'b0;
      rf_wr_addr  <= '0;
      rf_wr_data  <= '0;
      rf_rda_addr <= '0;
      rf_rdb_addr <= '0;
    end else begin
      rf_wr_en <= 1'b0;
      if (accept) begin
        prio        <= ~sel;
        rf_rda_addr <= cur.raddr0;
        rf_rdb_addr <= cur.raddr1;
        if (cur.we) begin
          rf_wr_en   <= 1'b1;
          rf_wr_addr <= cur.waddr;
          rf_wr_data <= cur.wdata;
        end
      end
    end
  end

  // Tag pipeline matches the register file's read latency plus our address register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      id_pipe  <= {id_pipe[STAGES-1:1], sel};
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_resp
    assign resp[g] = vld_pipe[STAGES] & (int'(id_pipe[STAGES]) == g);
  end

  assign a_ready      = ready[0];
  assign b_ready      = ready[1];
  assign a_resp_valid = resp[0];
  assign b_resp_valid = resp[1];
  assign resp_data0   = rf_rd_data1;
  assign resp_data1   = rf_rd_data2;

endmodule

// File: tb/tb_rf_arbiter.sv
// Directed bench for rf_arbiter with a behavioural register file model on the rf_* ports.
module tb_rf_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_valid, a_ready, a_we, b_valid, b_ready, b_we;
  logic [1:0] a_waddr, a_raddr0, a_raddr1, b_waddr, b_raddr0, b_raddr1;
  logic [7:0] a_wdata, b_wdata;
  logic       a_resp_valid, b_resp_valid;
  logic [7:0] resp_data0, resp_data1;
  logic       rf_wr_en;
  logic [1:0] rf_wr_addr, rf_rda_addr, rf_rdb_addr;
  logic [7:0] rf_wr_data, rf_rd_data1, rf_rd_data2;

  int n_cmp = 0;
  int n_err = 0;

  // register file model: addresses/enable captured at edge 1, data at edge 2
  logic [7:0] mem [4];
  logic       wen_q;
  logic [1:0] waddr_q, ra_q, rb_q;
  logic       pre_en = 1'b0;
  logic [1:0] pre_addr = '0;
  logic [7:0] pre_data = '0;
  logic [7:0] init_v [4];
  logic [7:0] exp0 [4];
  logic [7:0] exp1 [4];

  always @(posedge clk) begin
    wen_q   <= rf_wr_en;
    waddr_q <= rf_wr_addr;
    ra_q    <= rf_rda_addr;
    rb_q    <= rf_rdb_addr;
    if (wen_q) mem[waddr_q] <= rf_wr_data;
    else if (pre_en) mem[pre_addr] <= pre_data;
    rf_rd_data1 <= mem[ra_q];
    rf_rd_data2 <= mem[rb_q];
  end

  always #5 clk = ~clk;

  rf_arbiter #(.PRIO_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .a_raddr0(a_raddr0), .a_raddr1(a_raddr1),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .b_raddr0(b_raddr0), .b_raddr1(b_raddr1),
    .a_resp_valid(a_resp_valid), .b_resp_valid(b_resp_valid),
    .resp_data0(resp_data0), .resp_data1(resp_data1),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rda_addr(rf_rda_addr), .rf_rdb_addr(rf_rdb_addr),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2)
  );

  task automatic set_a(input logic v, input logic we, input logic [1:0] wa, input logic [7:0] wd,
                       input logic [1:0] r0, input logic [1:0] r1);
    a_valid = v; a_we = we; a_waddr = wa; a_wdata = wd; a_raddr0 = r0; a_raddr1 = r1;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [1:0] wa, input logic [7:0] wd,
                       input logic [1:0] r0, input logic [1:0] r1);
    b_valid = v; b_we = we; b_waddr = wa; b_wdata = wd; b_raddr0 = r0; b_raddr1 = r1;
  endtask

  task automatic preload();
    for (int i = 0; i < 4; i++) begin
      pre_en = 1'b1; pre_addr = 2'(i); pre_data = init_v[i];
      @(posedge clk); #1;
    end
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    set_a(1, 0, 0, 0, 0, 1);
    set_b(1, 0, 0, 0, 3, 2);
    #2 rst = 1'b1;
    preload();
    @(negedge clk); #1;
    n_cmp++; if ({a_ready, b_ready, a_resp_valid, b_resp_valid, rf_wr_en} !== 5'b0) begin n_err++;
      $display("FAIL rst_ctrl: got %b required 00000", {a_ready, b_ready, a_resp_valid, b_resp_valid, rf_wr_en}); end
    n_cmp++; if ({rf_wr_addr, rf_wr_data, rf_rda_addr, rf_rdb_addr} !== 14'h0) begin n_err++;
      $display("FAIL rst_rf: got %h required 0000", {rf_wr_addr, rf_wr_data, rf_rda_addr, rf_rdb_addr}); end
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if ({a_ready, b_ready} !== 2'b10) begin n_err++;
      $display("FAIL rst_first_grant: ready{a,b}=%b required 10", {a_ready, b_ready}); end
    @(negedge clk); a_valid = 0; b_valid = 0; #1;
    n_cmp++; if ({rf_rda_addr, rf_rdb_addr} !== 4'b0001) begin n_err++;
      $display("FAIL rst_rd_addr: got %b required 0001", {rf_rda_addr, rf_rdb_addr}); end
    @(negedge clk); #1;
    n_cmp++; if ({a_resp_valid, b_resp_valid} !== 2'b00) begin n_err++;
      $display("FAIL rst_resp_early: resp{a,b}=%b required 00", {a_resp_valid, b_resp_valid}); end
    @(negedge clk); #1;
    n_cmp++; if ({a_resp_valid, b_resp_valid, resp_data0, resp_data1} !== {2'b10, 8'h10, 8'h11}) begin n_err++;
      $display("FAIL rst_resp: got %b %h %h required 10 10 11", {a_resp_valid, b_resp_valid}, resp_data0, resp_data1); end
  endtask

  task automatic test_write_read();
    @(negedge clk); set_a(1, 1, 2, 8'hA5, 0, 0); b_valid = 0; #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL wr_accept: a_ready=%b required 1", a_ready); end
    @(negedge clk); set_b(1, 0, 0, 0, 2, 3); #1;
    n_cmp++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 2'd2, 8'hA5}) begin n_err++;
      $display("FAIL wr_n1: en/addr/data=%b/%0d/%h required 1/2/a5", rf_wr_en, rf_wr_addr, rf_wr_data); end
    n_cmp++; if ({a_ready, b_ready} !== 2'b00) begin n_err++;
      $display("FAIL wr_whold_ready: ready{a,b}=%b required 00", {a_ready, b_ready}); end
    @(negedge clk); a_valid = 0; #1;
    n_cmp++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b0, 2'd2, 8'hA5}) begin n_err++;
      $display("FAIL wr_n2: en/addr/data=%b/%0d/%h required 0/2/a5", rf_wr_en, rf_wr_addr, rf_wr_data); end
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL wr_follow_accept: b_ready=%b required 1", b_ready); end
    @(negedge clk); b_valid = 0; #1;
    n_cmp++; if ({a_resp_valid, b_resp_valid, resp_data0} !== {2'b10, 8'h10}) begin n_err++;
      $display("FAIL wr_resp_a: resp{a,b}=%b d0=%h required 10 10", {a_resp_valid, b_resp_valid}, resp_data0); end
    @(negedge clk); #1;
    n_cmp++; if ({a_resp_valid, b_resp_valid, rf_wr_en} !== 3'b000) begin n_err++;
      $display("FAIL wr_gap: resp{a,b},wr_en=%b required 000", {a_resp_valid, b_resp_valid, rf_wr_en}); end
    @(negedge clk); #1;
    n_cmp++; if ({a_resp_valid, b_resp_valid, resp_data0, resp_data1} !== {2'b01, 8'hA5, 8'h40}) begin n_err++;
      $display("FAIL wr_read_back: got %b %h %h required 01 a5 40", {a_resp_valid, b_resp_valid}, resp_data0, resp_data1); end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) begin set_a(1, 0, 0, 0, 0, 1); set_b(1, 0, 0, 0, 3, 2); end
      if (k == 4) begin a_valid = 0; b_valid = 0; end
      #1;
      if (k < 4) begin
        n_cmp++; if ({a_ready, b_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_err++;
          $display("FAIL rr_grant[%0d]: ready{a,b}=%b", k, {a_ready, b_ready}); end
      end
      if (k >= 3) begin
        n_cmp++;
        if ({a_resp_valid, b_resp_valid, resp_data0, resp_data1} !==
            (((k - 3) % 2 == 0) ? {2'b10, 8'h10, 8'h11} : {2'b01, 8'h40, 8'hA5})) begin n_err++;
          $display("FAIL rr_resp[%0d]: got %b %h %h", k, {a_resp_valid, b_resp_valid}, resp_data0, resp_data1); end
      end
    end
  endtask

  task automatic test_hazard();
    @(negedge clk); set_a(1, 1, 1, 8'h22, 1, 1); b_valid = 0; #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL hz_accept: a_ready=%b required 1", a_ready); end
    @(negedge clk); set_a(1, 0, 0, 0, 1, 0); #1;
    n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL hz_whold: a_ready=%b required 0", a_ready); end
    @(negedge clk); #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL hz_reaccept: a_ready=%b required 1", a_ready); end
    @(negedge clk); a_valid = 0; #1;
    n_cmp++; if ({a_resp_valid, resp_data0, resp_data1} !== {1'b1, 8'h11, 8'h11}) begin n_err++;
      $display("FAIL hz_old_value: got %b %h %h required 1 11 11", a_resp_valid, resp_data0, resp_data1); end
    @(negedge clk); #1;
    n_cmp++; if ({a_resp_valid, b_resp_valid} !== 2'b00) begin n_err++;
      $display("FAIL hz_gap: resp{a,b}=%b required 00", {a_resp_valid, b_resp_valid}); end
    @(negedge clk); #1;
    n_cmp++; if ({a_resp_valid, resp_data0, resp_data1} !== {1'b1, 8'h22, 8'h10}) begin n_err++;
      $display("FAIL hz_new_value: got %b %h %h required 1 22 10", a_resp_valid, resp_data0, resp_data1); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 4) begin a_valid = 0; set_b(1, 0, 0, 0, 2'(k), 2'(3 - k)); end
      if (k == 4) b_valid = 0;
      #1;
      if (k < 4) begin
        n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: b_ready=%b required 1", k, b_ready); end
      end
      if (k >= 3) begin
        n_cmp++;
        if ({a_resp_valid, b_resp_valid, resp_data0, resp_data1} !== {2'b01, exp0[k-3], exp1[k-3]}) begin n_err++;
          $display("FAIL b2b_resp[%0d]: got %b %h %h required 01 %h %h", k, {a_resp_valid, b_resp_valid},
                   resp_data0, resp_data1, exp0[k-3], exp1[k-3]); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); set_a(1, 0, 0, 0, 0, 1); b_valid = 0; #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL mf_rd_accept: a_ready=%b required 1", a_ready); end
    @(negedge clk); set_a(1, 1, 3, 8'hEE, 2, 2); #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL mf_wr_accept: a_ready=%b required 1", a_ready); end
    @(negedge clk); a_valid = 0; #1;
    n_cmp++; if (rf_wr_en !== 1'b1) begin n_err++; $display("FAIL mf_wr_en: rf_wr_en=%b required 1", rf_wr_en); end
    rst = 1'b1; #1;
    n_cmp++; if ({rf_wr_en, a_resp_valid, b_resp_valid, a_ready, b_ready, rf_wr_data} !== 13'h0) begin n_err++;
      $display("FAIL mf_rst_now: wr_en=%b resp=%b ready=%b wdata=%h required all 0", rf_wr_en,
               {a_resp_valid, b_resp_valid}, {a_ready, b_ready}, rf_wr_data); end
    @(negedge clk); #1;
    n_cmp++; if ({a_resp_valid, b_resp_valid} !== 2'b00) begin n_err++;
      $display("FAIL mf_rst_resp: resp{a,b}=%b required 00", {a_resp_valid, b_resp_valid}); end
    @(negedge clk); rst = 1'b0; set_a(1, 0, 0, 0, 0, 0); set_b(1, 0, 0, 0, 0, 0); #1;
    n_cmp++; if ({a_ready, b_ready} !== 2'b10) begin n_err++;
      $display("FAIL mf_prio_init: ready{a,b}=%b required 10", {a_ready, b_ready}); end
    a_valid = 0; b_valid = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      n_cmp++; if ({a_resp_valid, b_resp_valid, rf_wr_en} !== 3'b000) begin n_err++;
        $display("FAIL mf_quiet[%0d]: resp{a,b},wr_en=%b required 000", k, {a_resp_valid, b_resp_valid, rf_wr_en}); end
    end
    n_cmp++; if (mem[3] !== 8'h40) begin n_err++; $display("FAIL mf_no_commit: reg3=%h required 40", mem[3]); end
  endtask

  initial begin
    init_v = '{8'h10, 8'h11, 8'h02, 8'h40};
    exp0   = '{8'h10, 8'h22, 8'hA5, 8'h40};
    exp1   = '{8'h40, 8'hA5, 8'h22, 8'h10};
    test_reset();
    test_write_read();
    test_round_robin();
    test_hazard();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required finish");
    $fatal(1);
  end

endmodule
